// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// Holds the stall-vector width, named stall patterns, FSM encodings and the
// request-to-stall priority encoder.
package pipe_ctrl_pkg;

    localparam int unsigned StallBusW = 6;
    localparam int unsigned AddrW     = 32;
    localparam int unsigned WdogW     = 16;

    // Freeze vector bits: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
    localparam logic [StallBusW-1:0] StallNone = 6'b000000;
    localparam logic [StallBusW-1:0] StallIf   = 6'b000011;
    localparam logic [StallBusW-1:0] StallId   = 6'b000111;
    localparam logic [StallBusW-1:0] StallMem  = 6'b011111;

    localparam int unsigned ExMemBit = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_PEND  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // Priority mem > id > if
    function automatic logic [StallBusW-1:0] stall_encode(
        input logic req_if,
        input logic req_id,
        input logic req_mem
    );
        if (req_mem) begin
            return StallMem;
        end else if (req_id) begin
            return StallId;
        end else if (req_if) begin
            return StallIf;
        end
        return StallNone;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles, saturates at
// STALL_TIMEOUT and raises a sticky stall_timeout flag cleared only by reset.
// Ports: clk, rst (async active-low), stalled (any stall bit set this cycle),
//        stall_timeout (sticky error flag).
module pipe_ctrl_stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stalled,
    output logic stall_timeout
);

    localparam logic [WdogW-1:0] Limit   = WdogW'(STALL_TIMEOUT);
    localparam logic [WdogW-1:0] LimitM1 = WdogW'(STALL_TIMEOUT - 1);

    logic [WdogW-1:0] cnt;

    // Flag sets on the edge that completes the STALL_TIMEOUT-th stalled cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt           <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (!stalled) begin
                cnt <= '0;
            end else if (cnt != Limit) begin
                cnt <= cnt + WdogW'(1);
            end
            if (stalled && (cnt == LimitM1)) begin
                stall_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the five-stage core.
// Merges IF/ID/MEM stall requests into a per-stage freeze vector, sequences
// taken-branch redirects into a registered one-cycle flush/new_pc pulse
// (holding them while EX/MEM is frozen), and runs a stall watchdog.
// Ports: clk, rst (async active-low), stallreq_if/id/mem (level requests),
//        branch_flag/branch_target (EX redirect), stall (combinational freeze
//        vector), flush/new_pc (registered redirect), stall_timeout (sticky),
//        stall_cycles (only when PIPE_CTRL_PERF_EN is defined).
// Macro: PIPE_CTRL_PERF_EN adds the PERF_W parameter and stall_cycles counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 1024
`ifdef PIPE_CTRL_PERF_EN
   ,parameter int unsigned PERF_W        = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallreq_if,
    input  logic                 stallreq_id,
    input  logic                 stallreq_mem,
    input  logic                 branch_flag,
    input  logic [AddrW-1:0]     branch_target,
    output logic [StallBusW-1:0] stall,
    output logic                 flush,
    output logic [AddrW-1:0]     new_pc,
    output logic                 stall_timeout
`ifdef PIPE_CTRL_PERF_EN
   ,output logic [PERF_W-1:0]    stall_cycles
`endif
);

    state_e           state;
    state_e           state_n;
    logic             any_req;
    logic             accept;
    logic [AddrW-1:0] target_q;

    assign any_req = stallreq_if | stallreq_id | stallreq_mem;

    // Zero-latency freeze vector; forced clear while flushing
    always_comb begin
        stall = stall_encode(stallreq_if, stallreq_id, stallreq_mem);
        if (state == ST_FLUSH) begin
            stall = StallNone;
        end
    end

    // Next-state: a redirect is accepted in RUN/HOLD only
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            ST_RUN, ST_HOLD: begin
                if (branch_flag) begin
                    accept  = 1'b1;
                    state_n = stall[ExMemBit] ? ST_PEND : ST_FLUSH;
                end else if (any_req) begin
                    state_n = ST_HOLD;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_PEND: begin
                if (!stall[ExMemBit]) begin
                    state_n = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_n = any_req ? ST_HOLD : ST_RUN;
            end
            default: state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            target_q <= '0;
            flush    <= 1'b0;
            new_pc   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                target_q <= branch_target;
            end
            flush <= (state_n == ST_FLUSH);
            // Direct RUN/HOLD->FLUSH bypasses target_q
            if (state_n == ST_FLUSH) begin
                new_pc <= accept ? branch_target : target_q;
            end
        end
    end

    pipe_ctrl_stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stalled      (stall != StallNone),
        .stall_timeout(stall_timeout)
    );

`ifdef PIPE_CTRL_PERF_EN
    // Counts PC-frozen cycles, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else begin
            stall_cycles <= stall_cycles + PERF_W'(stall[0]);
        end
    end
`endif

endmodule
